// File: rtl/bm_last_stage_ctrl.sv
`timescale 1ns/1ps
// bm_last_stage_ctrl
// Row scheduler for the normalization-backward last stage. For every row it
// streams BEATS = hidden_num/N beats of dz, max/min index and
// weight/variance_rec into the stage, then tracks the gradx beats returning
// from it. The stage cannot be stalled, so a beat is only issued while the
// output FIFO is known to have a free slot (one credit per FIFO entry).
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   start, num_rows, mode_in      job request (num_rows/mode_in sampled on start)
//   busy, done, err, mode         job status, sticky error, latched mode
//   scal_valid, scal_ack          per-row scalar handshake with upstream unit
//   dz_rd_en, dz_rd_addr          dz/index buffer read (1-cycle latency)
//   w_rd_en, w_rd_addr            weight/variance buffer read (1-cycle latency)
//   in_valid, in_last             stage dz path strobes
//   param_valid, param_last       stage param path strobes
//   gradx_out_valid/_last         returning gradx beats from the stage
//   ofifo_pop                     output FIFO read, returns one credit
module bm_last_stage_ctrl #(
  parameter int N          = 8,
  parameter int hidden_num = 16,
  parameter int ADDR_W     = 8,
  parameter int ROW_W      = 16,
  parameter int OUT_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic              mode_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mode,
  input  logic              scal_valid,
  output logic              scal_ack,
  output logic              dz_rd_en,
  output logic [ADDR_W-1:0] dz_rd_addr,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              in_valid,
  output logic              in_last,
  output logic              param_valid,
  output logic              param_last,
  input  logic              gradx_out_valid,
  input  logic              gradx_out_last,
  input  logic              ofifo_pop
);

  localparam int BEATS  = hidden_num / N;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = ROW_W + BEAT_W + 1;
  // Headroom for OUT_DEPTH+1 so an unmatched pop can be detected.
  localparam int CRED_W = $clog2(OUT_DEPTH + 2);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_SCAL = 2'd1;
  localparam logic [1:0] S_ISSUE     = 2'd2;
  localparam logic [1:0] S_DRAIN     = 2'd3;

  logic [1:0]        state;
  logic [ROW_W-1:0]  num_rows_q;
  logic [ROW_W-1:0]  row;
  logic [BEAT_W-1:0] beat;
  logic [CRED_W-1:0] credit;
  logic [CNT_W-1:0]  iss_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic [BEAT_W-1:0] ret_beat;

  logic              issue;
  logic              last_beat;
  logic              last_row;
  logic              start_ok;
  logic [CNT_W-1:0]  total;
  logic [CRED_W-1:0] credit_sum;
  logic              credit_ovf;
  logic              ret_spurious;
  logic              ret_ok;
  logic              ret_row_end;
  logic              last_err;
  logic              scal_drop_err;
  logic              err_set;
  logic [CNT_W-1:0]  ret_cnt_next;

  // Issue/credit/return-check decode. A beat goes out whenever we are in
  // ISSUE with a credit in hand; a stalled beat simply leaves a bubble.
  // A returning beat that arrives with nothing outstanding is flagged and
  // not counted, so it cannot make the drain finish early.
  always_comb begin
    issue         = (state == S_ISSUE) && (credit != '0);
    last_beat     = (beat == BEAT_W'(BEATS - 1));
    last_row      = (row == (num_rows_q - ROW_W'(1)));
    start_ok      = (state == S_IDLE) && start;
    total         = CNT_W'(num_rows_q) * CNT_W'(BEATS);
    credit_sum    = credit + CRED_W'(ofifo_pop) - CRED_W'(issue);
    credit_ovf    = (credit_sum > CRED_W'(OUT_DEPTH));
    ret_spurious  = gradx_out_valid && (ret_cnt == iss_cnt);
    ret_ok        = gradx_out_valid && !ret_spurious;
    ret_row_end   = (ret_beat == BEAT_W'(BEATS - 1));
    last_err      = ret_ok && (gradx_out_last != ret_row_end);
    scal_drop_err = (state == S_ISSUE) && !scal_valid;
    err_set       = scal_drop_err | credit_ovf | last_err | ret_spurious;
    ret_cnt_next  = ret_cnt + CNT_W'(ret_ok);
  end

  // Buffer reads are driven straight from the issue decision so the data
  // appears one cycle later, aligned with in_valid/param_valid.
  assign dz_rd_en   = issue;
  assign w_rd_en    = issue;
  assign dz_rd_addr = ADDR_W'(row) * ADDR_W'(BEATS) + ADDR_W'(beat);
  assign w_rd_addr  = ADDR_W'(beat);

  // Row sequencing. A zero-row job only produces a done pulse. The drain
  // completes as soon as the beat returning this cycle brings the count up
  // to the full job size, so done follows the final gradx beat by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      num_rows_q <= '0;
      row        <= '0;
      beat       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_rows != '0) begin
              num_rows_q <= num_rows;
              mode       <= mode_in;
              row        <= '0;
              beat       <= '0;
              busy       <= 1'b1;
              state      <= S_WAIT_SCAL;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_WAIT_SCAL: begin
          if (scal_valid) begin
            beat  <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            if (last_beat) begin
              beat <= '0;
              if (last_row) begin
                state <= S_DRAIN;
              end else begin
                row   <= row + ROW_W'(1);
                state <= S_WAIT_SCAL;
              end
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (ret_cnt_next == total) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Credit pool, issued/returned beat counters and the sticky error flag.
  // Credits saturate at OUT_DEPTH when a pop has no matching entry. A new
  // job clears the error and the beat bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit   <= CRED_W'(OUT_DEPTH);
      iss_cnt  <= '0;
      ret_cnt  <= '0;
      ret_beat <= '0;
      err      <= 1'b0;
    end else begin
      credit <= credit_ovf ? CRED_W'(OUT_DEPTH) : credit_sum;
      err    <= (err & ~start_ok) | err_set;
      if (start_ok) begin
        iss_cnt  <= '0;
        ret_cnt  <= '0;
        ret_beat <= '0;
      end else begin
        iss_cnt <= iss_cnt + CNT_W'(issue);
        ret_cnt <= ret_cnt_next;
        if (ret_ok) begin
          ret_beat <= ret_row_end ? '0 : ret_beat + BEAT_W'(1);
        end
      end
    end
  end

  // Stage strobes: the read enables delayed by the buffer latency. The row's
  // final beat also acknowledges the row scalars to the upstream unit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_valid    <= 1'b0;
      param_valid <= 1'b0;
      in_last     <= 1'b0;
      param_last  <= 1'b0;
      scal_ack    <= 1'b0;
    end else begin
      in_valid    <= issue;
      param_valid <= issue;
      in_last     <= issue && last_beat;
      param_last  <= issue && last_beat;
      scal_ack    <= issue && last_beat;
    end
  end

endmodule
